// File: rtl/demux4_frame.sv
// Receive side of the ALU 4:1 operand/result mux: collects a 4-beat, SOF-framed
// stream into four channel registers and presents them with a valid/ready handshake.
module demux4_frame #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             frame_valid,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic             frame_err,
  input  logic             clr_err
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] stage0, stage1, stage2;
  logic             accept, complete, err_set;

  // Only the frame-completing beat can stall, and only while an unconsumed
  // frame would be overwritten; depends on out_ready but never on in_valid.
  assign in_ready = ~((state == RECV) && (cnt == 2'd3) && frame_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && (state == RECV) && !in_sof && (cnt == 2'd3);
  assign err_set  = accept && (((state == IDLE) && !in_sof) || ((state == RECV) && in_sof));

  // NOTE: all state is registered with non-blocking assignments so every
  // register samples pre-edge values; blocking here would chain updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      stage0      <= '0;
      stage1      <= '0;
      stage2      <= '0;
      Q0          <= '0;
      Q1          <= '0;
      Q2          <= '0;
      Q3          <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (in_sof) begin
          // A new SOF always restarts at channel 0, aborting any partial frame.
          stage0 <= in_data;
          cnt    <= 2'd1;
          state  <= RECV;
        end else if (state == RECV) begin
          case (cnt)
            2'd1: begin
              stage1 <= in_data;
              cnt    <= 2'd2;
            end
            2'd2: begin
              stage2 <= in_data;
              cnt    <= 2'd3;
            end
            default: begin
              cnt   <= 2'd0;
              state <= IDLE;
            end
          endcase
        end
      end

      if (complete) begin
        Q0          <= stage0;
        Q1          <= stage1;
        Q2          <= stage2;
        Q3          <= in_data;
        frame_valid <= 1'b1;
      end else if (out_ready) begin
        frame_valid <= 1'b0;
      end

      if (err_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/demux4_frame.md
Name: demux4_frame

Overview:
- Receive side of the ALU's 4:1 operand/result multiplexing path.
- Accepts a time-multiplexed stream of WIDTH-bit beats, one channel per beat, framed by a start-of-frame flag.
- Assembles each 4-beat frame into four parallel registers (channels 0..3) and presents them atomically with a valid/ready handshake toward the consumer.

Parameters:
- WIDTH, 4, bits per channel word (4 matches the ALU datapath).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  beat present on in_data.
- in_sof  input  1  beat is channel 0 of a new frame; qualified by in_valid.
- in_data  input  WIDTH  beat payload.
- in_ready  output  1  block accepts the beat this cycle.
- out_ready  input  1  consumer takes the current frame.
- frame_valid  output  1  Q0..Q3 hold an unconsumed complete frame.
- Q0, Q1, Q2, Q3  output  WIDTH each  channel 0..3 of the last completed frame.
- frame_err  output  1  sticky protocol-error flag.
- clr_err  input  1  synchronous clear of frame_err.

Behaviour:
- Beat accepted on a rising edge when in_valid & in_ready.
- Reset (asynchronous, any time including mid-frame):
  - state=IDLE, cnt=0, staging regs=0, Q0..Q3=0, frame_valid=0, frame_err=0.
  - Any partial frame is discarded.
- States: IDLE (waiting for SOF), RECV (cnt = next channel index, 1..3). cnt is 2 bits.
- IDLE:
  - Accepted beat with in_sof=1: stage0<=in_data, cnt<=1, go to RECV.
  - Accepted beat with in_sof=0: dropped, frame_err<=1, stay in IDLE.
- RECV, accepted beat with in_sof=0:
  - cnt 1 or 2: stage[cnt]<=in_data, cnt<=cnt+1.
  - cnt 3: on the same edge, Q0<=stage0, Q1<=stage1, Q2<=stage2, Q3<=in_data (atomic update); frame_valid<=1; cnt<=0; go to IDLE.
- RECV, accepted beat with in_sof=1 (premature SOF):
  - Partial frame aborted; frame_err<=1.
  - Beat treated as a new channel 0: stage0<=in_data, cnt<=1, stay in RECV.
  - Q0..Q3 and frame_valid unchanged.
- in_ready (combinational) = ~(state==RECV & cnt==3 & frame_valid & ~out_ready).
  - Only the completing beat is back-pressured; beats 0..2 are always accepted.
  - in_ready may depend combinationally on out_ready; no combinational path from in_valid to in_ready.
- Output handshake:
  - frame_valid clears on an edge with out_ready=1, unless a new frame completes on that same edge; in that case frame_valid stays 1 and Q takes the new frame.
  - Q0..Q3 are stable while frame_valid=1 and out_ready=0.
- Latency: Q and frame_valid update on the edge that accepts beat 3. Earliest frame_valid is the cycle after the 4th consecutive accepted beat.
- Error flag:
  - frame_err set/clear priority: set wins over clr_err on the same edge.
  - Holds until cleared or reset.
- in_valid=0: no state change except the output handshake.

Test Plan:
- Reset then beats SOF/3, 5, A, C on consecutive cycles with out_ready=1 -> in_ready always 1; after the 4th edge Q0..Q3=3,5,A,C, frame_valid=1 for one cycle, frame_err=0.
- Two back-to-back frames (1,2,3,4 then 9,8,7,6) with out_ready=0 until cycle 10 -> first frame held stable; in_ready=0 only while presenting beat 6; beat 6 accepted the cycle out_ready rises, Q=9,8,7,6.
- Beats 0xF, 0xE without SOF from IDLE, then SOF frame 1,1,1,1 -> the two beats dropped, frame_err=1, Q=1,1,1,1; pulse clr_err -> frame_err=0.
- SOF/2, 4, then SOF/6, 7, 8, 9 -> frame_err=1; no output after the aborted frame; final Q=6,7,8,9.
- Gaps: SOF/A, idle 3 cycles, B, idle, C, D -> Q=A,B,C,D; frame_valid only after D.
- Assert rst asynchronously between beat 2 and beat 3 of a frame after a prior valid frame -> Q=0, frame_valid=0 immediately. A following non-SOF beat sets frame_err; a following clean frame completes correctly.
